// File: rtl/ppwm_pkg.sv
// rtl/ppwm_pkg.sv - shared constants and types for the multi-channel PWM block
package ppwm_pkg;

  // Register map
  localparam int ADDR_PERIOD   = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_CTRL     = 2;
  localparam int ADDR_DUTY0    = 3;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CENTER_BIT = 1;

  // Period counter direction (only leaves DIR_UP in center-aligned mode)
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

endpackage

// File: rtl/ppwm_prescaler.sv
// rtl/ppwm_prescaler.sv - clock prescaler producing one tick every PRESCALE+1 cycles
module ppwm_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  // A new prescale value is compared immediately; if pre_cnt is already past
  // it, the count runs on to the natural wrap of the register.
  assign tick = enable && (pre_cnt == prescale);

  // Free count while enabled, held at zero otherwise
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ppwm_multi.sv
// rtl/ppwm_multi.sv - shadowed multi-channel PWM generator, center mode under PPWM_CENTER_ALIGNED_EN
module ppwm_multi
  import ppwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 4,
  localparam int AW        = $clog2(CHANNELS + 3)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic                busy
);

  // Shadow (software-visible) registers
  logic [WIDTH-1:0]      period_sh;
  logic [PRESCALE_W-1:0] prescale;
  logic                  ctrl_en;
  logic                  ctrl_center;
  logic [WIDTH-1:0]      duty_sh [CHANNELS];

  // Active copies, reloaded only at a period boundary while running
  logic [WIDTH-1:0]      period_act;
  logic [WIDTH-1:0]      duty_act [CHANNELS];
  logic                  center_act;

  logic [WIDTH-1:0]      cnt;
  logic [WIDTH-1:0]      cnt_next;
  dir_e                  dir;
  dir_e                  dir_next;
  logic                  wrap;
  logic                  tick;
  logic                  wr_ctrl;
  logic                  en_next;
  logic                  run;
  logic [CHANNELS-1:0]   cmp;

  // Looking at the enable value about to be written lets a clearing write
  // drop the outputs on the very next cycle, while a setting write only
  // starts the count one cycle later (from cnt = 0).
  assign wr_ctrl = cfg_we && (cfg_addr == AW'(ADDR_CTRL));
  assign en_next = wr_ctrl ? cfg_wdata[CTRL_EN_BIT] : ctrl_en;
  assign run     = ctrl_en && en_next;
  assign busy    = ctrl_en;

  ppwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (run),
    .prescale (prescale),
    .tick     (tick)
  );

  // Register file: write-only, every strobe accepted, unknown addresses dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_sh   <= '1;
      prescale    <= '0;
      ctrl_en     <= 1'b0;
      ctrl_center <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_sh[i] <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == AW'(ADDR_PERIOD))   period_sh <= cfg_wdata;
      if (cfg_addr == AW'(ADDR_PRESCALE)) prescale  <= cfg_wdata[PRESCALE_W-1:0];
      if (wr_ctrl) begin
        ctrl_en <= cfg_wdata[CTRL_EN_BIT];
`ifdef PPWM_CENTER_ALIGNED_EN
        ctrl_center <= cfg_wdata[CTRL_CENTER_BIT];
`else
        ctrl_center <= 1'b0;
`endif
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_addr == AW'(ADDR_DUTY0 + i)) duty_sh[i] <= cfg_wdata;
      end
    end
  end

  // Next counter value and wrap detection for the current mode
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    wrap     = 1'b0;
    if (tick) begin
      if (center_act) begin
        if (dir == DIR_UP) begin
          if (cnt == period_act) begin
            if (period_act <= WIDTH'(1)) begin
              // Peak and valley coincide: the turn-around is also the wrap
              cnt_next = '0;
              wrap     = 1'b1;
            end else begin
              cnt_next = cnt - 1'b1;
              dir_next = DIR_DOWN;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
          if (cnt == WIDTH'(1)) begin
            wrap     = 1'b1;
            dir_next = DIR_UP;
          end
        end
      end else begin
        if (cnt == period_act) begin
          cnt_next = '0;
          wrap     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  // Period counter, direction and boundary pulse; all cleared while stopped
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      dir         <= dir_next;
      period_tick <= wrap;
    end
  end

  // Active registers follow the shadows while stopped, else only at a wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_act <= '1;
      center_act <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= '0;
    end else if (!run || wrap) begin
      period_act <= period_sh;
      center_act <= ctrl_center;
      for (int i = 0; i < CHANNELS; i++) duty_act[i] <= duty_sh[i];
    end
  end

  // Per-channel compare. Center mode splits the high window across the
  // peak so that it spans exactly 2*duty ticks: duty states on the way up
  // (including the peak) and duty states on the way down.
  always_comb begin
    cmp = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (center_act) begin
        cmp[i] = (duty_act[i] != '0) &&
                 ((duty_act[i] >= period_act) ||
                  ((dir == DIR_UP) ?
                   (({1'b0, cnt} + {1'b0, duty_act[i]}) >  {1'b0, period_act}) :
                   (({1'b0, cnt} + {1'b0, duty_act[i]}) >= {1'b0, period_act})));
      end else begin
        cmp[i] = cnt < duty_act[i];
      end
    end
  end

  // Registered outputs, one cycle behind cnt
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= cmp;
    end
  end

endmodule

// File: doc/ppwm_multi.md
Name: ppwm_multi

Overview:
Parametrised multi-channel PWM generator and the successor to the single free-running 8-bit counter. All channels share one prescaled period counter. Each channel has its own duty register. Period and duty values are shadowed and take effect only at a period boundary, so updates are glitch-free. Configuration uses a simple write-only register port driven from the chip-level IO wrapper.

Parameters:
- WIDTH, 8, width of the period counter, the period register and each duty register.
- CHANNELS, 4, number of PWM outputs (1..16).
- PRESCALE_W, 4, width of the clock prescaler register.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- cfg_we  input  1  single-cycle register write strobe; always accepted, no back-pressure.
- cfg_addr  input  AW  register address; AW = $clog2(CHANNELS+3).
- cfg_wdata  input  WIDTH  write data; upper bits are ignored for narrower registers.
- pwm_out  output  CHANNELS  registered PWM outputs.
- period_tick  output  1  one-cycle pulse when the counter wraps (period boundary).
- busy  output  1  high while ctrl.enable = 1.

Behaviour:
- Register map:
  - 0: PERIOD shadow (reset 2^WIDTH-1).
  - 1: PRESCALE (reset 0).
  - 2: CTRL, bit0 = enable, bit1 = center mode (reset 0).
  - 3..3+CHANNELS-1: DUTY[i] shadow (reset 0).
  - Writes to any other address are ignored.
- Prescaler:
  - pre_cnt counts 0..PRESCALE; a tick is generated when pre_cnt == PRESCALE, then pre_cnt returns to 0.
  - PRESCALE = 0 gives a tick every clk.
  - PRESCALE written mid-count applies immediately. If pre_cnt > new PRESCALE, pre_cnt wraps at 2^PRESCALE_W-1; this is accepted behaviour.
- Edge-aligned mode (default):
  - On each tick, cnt increments.
  - When cnt == period_act, cnt wraps to 0, period_tick pulses, and period_act / duty_act[i] load from the shadows.
  - PWM period is (PERIOD+1)*(PRESCALE+1) clk cycles.
- Output rule:
  - pwm_out[i] <= enable && (cnt < duty_act[i]), registered, so it lags cnt by one cycle.
  - Duty 0 gives a constant low.
  - Duty > PERIOD gives a constant high.
- Shadow load timing:
  - A write in the same cycle as a wrap is not loaded; the pre-write shadow value loads, and the new value applies at the next wrap.
- Disabled state (enable = 0):
  - cnt, pre_cnt, pwm_out and period_tick are 0.
  - Active registers track the shadows every cycle.
- Enable behaviour:
  - A write that sets enable starts counting from cnt = 0 on the following cycle.
  - The first period is always complete, with no runt pulse.
  - Clearing enable forces all outputs low on the next cycle.
- Reset: all registers return to their reset values and all outputs are 0, regardless of an operation in progress.
- Arithmetic: unsigned; cnt is never compared beyond WIDTH bits.

Optional Feature:
- Macro: PPWM_CENTER_ALIGNED_EN.
- Defined:
  - CTRL.bit1 selects center-aligned mode. cnt counts up 0..period_act, then down to 0; the direction flips at each end.
  - Wrap (shadow load plus period_tick) occurs when cnt reaches 0 while counting down.
  - PWM period is 2*PERIOD*(PRESCALE+1) clk cycles; high time is 2*DUTY ticks, symmetric about the peak.
  - Toggling the mode bit while enabled applies at the next wrap.
- Undefined:
  - CTRL.bit1 is ignored (stored as 0) and the block is edge-aligned only.

Decomposition:
- Package ppwm_pkg holds:
  - address constants ADDR_PERIOD, ADDR_PRESCALE, ADDR_CTRL, ADDR_DUTY0;
  - CTRL bit indices CTRL_EN_BIT, CTRL_CENTER_BIT;
  - a typedef enum {DIR_UP, DIR_DOWN} for the counter direction.
- Sub-module ppwm_prescaler (PRESCALE_W, enable, prescale value → tick) is natural.
- The register file and the compare logic stay in the top module.

Test Plan:
1. WIDTH=8, CHANNELS=4, PERIOD=9, PRESCALE=0, DUTY={3,0,10,5}, enable → ch0 high 3 of every 10 clk, ch1 always 0, ch2 always 1, ch3 high 5 of 10, period_tick every 10 clk.
2. Mid-period, write DUTY0=7 at cnt=4 → current period stays 3-high; the next period is 7-high; no runt or double pulse.
3. PRESCALE=3, PERIOD=9, DUTY0=3 → period 40 clk, ch0 high 12 clk, period_tick every 40 clk.
4. Clear enable at cnt=5, then re-enable 7 cycles later → outputs go 0 the next cycle and busy=0; after re-enable, cnt restarts at 0 and the first period is full length.
5. Assert rst_n=0 mid-period with PERIOD=9 → next cycle all pwm_out=0, PERIOD reads back as 255 behaviour (256-tick period once enabled), DUTY=0.
6. With PPWM_CENTER_ALIGNED_EN: PERIOD=4, DUTY0=2, center mode → period 8 clk, ch0 high 4 consecutive clk centered on cnt=4, period_tick once per 8 clk.
